// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into one-cycle press/release/long/repeat events.
// Defining AUTO_REPEAT_EN enables periodic repeat_pulse while the button is in long hold.
`timescale 1ns/1ps
module button_event_gen #(
    parameter int unsigned LONG_COUNT   = 50000000,
    parameter int unsigned REPEAT_COUNT = 10000000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clean_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       long_held,
    output logic [7:0] press_count
);

    localparam int unsigned PCNT_W = 8;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               lvl_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic               repeat_q, repeat_d;
    logic               held_q, held_d;
    logic [PCNT_W-1:0]  press_count_q, press_count_d;
    logic               rise_c, fall_c;

    assign rise_c = clean_level & ~lvl_q;
    assign fall_c = ~clean_level & lvl_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a fall always takes priority over a terminal count
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rise_c) state_d = S_PRESSED;
            end
            S_PRESSED: begin
                if (fall_c)                  state_d = S_IDLE;
                else if (cnt_q == LONG_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (fall_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and counter next values
    always_comb begin
        cnt_d         = cnt_q;
        press_d       = 1'b0;
        release_d     = 1'b0;
        long_d        = 1'b0;
        repeat_d      = 1'b0;
        held_d        = 1'b0;
        press_count_d = press_count_q;
        case (state_q)
            S_IDLE: begin
                if (rise_c) begin
                    press_d       = 1'b1;
                    press_count_d = press_count_q + PCNT_W'(1);
                    cnt_d         = '0;
                end
            end
            S_PRESSED: begin
                if (fall_c) begin
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    long_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                held_d = ~fall_c;
                if (fall_c) begin
                    release_d = 1'b1;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: cnt_d = '0;
        endcase
    end

`ifndef AUTO_REPEAT_EN
    logic unused_rep_last;
    assign unused_rep_last = ^REP_LAST;
`endif

    // Level history, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q         <= 1'b0;
            cnt_q         <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            lvl_q         <= clean_level;
            cnt_q         <= cnt_d;
            press_q       <= press_d;
            release_q     <= release_d;
            long_q        <= long_d;
            repeat_q      <= repeat_d;
            held_q        <= held_d;
            press_count_q <= press_count_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign long_held     = held_q;
    assign press_count   = press_count_q;

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumer end of the switch-conditioning path. Takes a debounced, already-synchronous button level and decodes it into single-cycle events: press, release, long-press and auto-repeat.
- Also provides a held-state level and a press counter.
- Sits between the debouncer outputs and the tile-flip game control logic. Game FSMs consume pulses only, never raw levels.

Parameters:
- LONG_COUNT, 50000000, cycles from press_pulse to long_pulse (>=2).
- REPEAT_COUNT, 10000000, cycles between successive repeat_pulse events in long-hold (>=2).
- CNT_W, 26, hold counter width; must hold max(LONG_COUNT, REPEAT_COUNT)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clean_level  input  1  debounced button level, 1 = pressed, synchronous to clk.
- press_pulse  output  1  one-cycle pulse on 0->1 of clean_level.
- release_pulse  output  1  one-cycle pulse on 1->0 of clean_level.
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_COUNT.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_COUNT cycles during long hold.
- long_held  output  1  level, high while in HOLD state.
- press_count  output  8  number of press events since reset, wraps 255->0.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, lvl_q=0, cnt=0.
  - All outputs 0, press_count=0.
- lvl_q <= clean_level every cycle.
- rise = clean_level & ~lvl_q; fall = ~clean_level & lvl_q.
- All outputs are registered. Each event pulse is high for exactly the one cycle following the clock edge at which its condition is detected (1-cycle latency).
- FSM states IDLE, PRESSED, HOLD; 2-bit encoding; unused code returns to IDLE.
- IDLE:
  - On rise: press_pulse=1, press_count+1, cnt<=0, go PRESSED.
  - Otherwise stay.
- PRESSED:
  - On fall: release_pulse=1, go IDLE.
  - Else if cnt==LONG_COUNT-1: long_pulse=1, cnt<=0, go HOLD.
  - Else cnt+1.
  - long_pulse therefore rises exactly LONG_COUNT cycles after press_pulse.
- HOLD:
  - long_held=1.
  - On fall: release_pulse=1, long_held<=0, go IDLE.
  - Else if cnt==REPEAT_COUNT-1: repeat_pulse=1, cnt<=0.
  - Else cnt+1.
  - First repeat_pulse is REPEAT_COUNT cycles after long_pulse, then periodic.
- Simultaneous events:
  - fall on the same edge as a terminal count: release wins, and no long_pulse or repeat_pulse is issued.
  - At most one event pulse is high in any cycle.
- Press released before LONG_COUNT: press_pulse then release_pulse only, no long_pulse.
- clean_level high when reset deasserts: lvl_q=0, so press_pulse fires on the first edge (counts as a press).
- Reset mid-hold: immediate return to IDLE, outputs cleared. No release_pulse is generated for the aborted press.
- press_count arithmetic is modulo 256; the counter is unaffected by long or repeat events.
- cnt never exceeds max(LONG_COUNT, REPEAT_COUNT)-1; no overflow.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: HOLD behaves as above, periodic repeat_pulse.
- Undefined:
  - repeat_pulse is tied to 0 and cnt is held at 0 in HOLD.
  - long_held and release behaviour are unchanged.
  - REPEAT_COUNT is unused.

Test Plan (LONG_COUNT=8, REPEAT_COUNT=4, AUTO_REPEAT_EN defined unless noted):
- Reset with clean_level=0, release, idle 20 cycles -> all outputs 0, press_count=0.
- clean_level 0->1 held 5 cycles then 0 -> press_pulse 1 cycle after the rising edge is sampled; release_pulse 1 cycle after the fall; no long_pulse; press_count=1.
- clean_level held high 30 cycles -> press_pulse at t, long_pulse at t+8, long_held high from t+9, repeat_pulse at t+12, t+16, t+20, ...; release -> release_pulse, long_held low next cycle.
- Fall timed on the same edge as cnt==LONG_COUNT-1 -> release_pulse only; long_pulse never asserts; state IDLE.
- 257 short presses -> press_count=1 (wrap); reset asserted mid-HOLD -> all outputs 0 immediately, no release_pulse.
- AUTO_REPEAT_EN undefined, hold 30 cycles -> long_pulse at t+8, repeat_pulse never high, long_held high until release.
